// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//   Round-robin arbiter and sequencer for a memory bus shared by NUM_PROC
//   processors. One processor owns the bus at a time. The owner's address,
//   store data and direction are latched onto the memory port, and load data
//   comes back to the owner with a one-cycle valid_mem pulse.
//
// Ports
//   clk, reset_n      clock; asynchronous active-low reset
//   req[NUM_PROC]     per-processor bus request
//   valid[NUM_PROC]   per-processor address/data valid (sampled for the owner only)
//   rw[NUM_PROC]      per-processor direction: 1 = load, 0 = store
//   address, wdata    packed per-processor address / store data, proc i at [i*W +: W]
//   ack[NUM_PROC]     one-hot grant, held for the whole tenure
//   busy              arbiter not in IDLE
//   valid_mem         one-cycle pulse to the owner when rdata holds load data
//   rdata             load data, broadcast to all processors
//   grant_id          index of the current or most recent owner
//   timeout_err       one-cycle pulse when a grant is revoked for lack of valid
//   mem_valid         one-cycle request strobe to the memory controller
//   mem_addr/wdata/rw latched access of the owner, stable until the next access
//   mem_ready         memory finished the access (only honoured in WAIT_MEM)
//   mem_rdata         memory load data, qualified by mem_ready
//   dbg_state_o       current FSM state (IDLE=0, GRANT=1, WAIT_MEM=2, RELEASE=3)
//
// Handshake: a processor raises req and keeps it high for as long as it wants
// the bus. ack[i] rising means processor i owns the bus; the owner then raises
// valid together with address/wdata/rw, and the access is captured on the first
// edge where valid is seen. Loads finish with a valid_mem pulse; ack falls at
// the end of every tenure. Dropping req before valid abandons the tenure.
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
   parameter int NUM_PROC = 4,
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 8,
   parameter int TIMEOUT  = 16
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [NUM_PROC-1:0]          req,
   input  logic [NUM_PROC-1:0]          valid,
   input  logic [NUM_PROC-1:0]          rw,
   input  logic [NUM_PROC*ADDR_W-1:0]   address,
   input  logic [NUM_PROC*DATA_W-1:0]   wdata,
   output logic [NUM_PROC-1:0]          ack,
   output logic                         busy,
   output logic [NUM_PROC-1:0]          valid_mem,
   output logic [DATA_W-1:0]            rdata,
   output logic [$clog2(NUM_PROC)-1:0]  grant_id,
   output logic                         timeout_err,
   output logic                         mem_valid,
   output logic [ADDR_W-1:0]            mem_addr,
   output logic [DATA_W-1:0]            mem_wdata,
   output logic                         mem_rw,
   input  logic                         mem_ready,
   input  logic [DATA_W-1:0]            mem_rdata,
   output logic [1:0]                   dbg_state_o
);

   localparam int GW = $clog2(NUM_PROC);
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_GRANT    = 2'd1,
      ST_WAIT_MEM = 2'd2,
      ST_RELEASE  = 2'd3
   } state_t;

   state_t               state_q,       state_d;
   logic [NUM_PROC-1:0]  ack_q,         ack_d;
   logic                 busy_q,        busy_d;
   logic [NUM_PROC-1:0]  valid_mem_q,   valid_mem_d;
   logic [DATA_W-1:0]    rdata_q,       rdata_d;
   logic [GW-1:0]        grant_id_q,    grant_id_d;
   logic                 timeout_err_q, timeout_err_d;
   logic                 mem_valid_q,   mem_valid_d;
   logic [ADDR_W-1:0]    mem_addr_q,    mem_addr_d;
   logic [DATA_W-1:0]    mem_wdata_q,   mem_wdata_d;
   logic                 mem_rw_q,      mem_rw_d;
   logic [CW-1:0]        cnt_q,         cnt_d;
   logic [GW-1:0]        last_grant_q,  last_grant_d;

   logic [ADDR_W-1:0]    addr_a  [NUM_PROC];
   logic [DATA_W-1:0]    wdata_a [NUM_PROC];
   logic [GW-1:0]        win_idx;
   logic [NUM_PROC-1:0]  owner_oh;

   // Round-robin pick: the first requester strictly above 'last', otherwise
   // the first requester at or below it, so the previous owner ranks last.
   function automatic logic [GW-1:0] rr_pick(input logic [NUM_PROC-1:0] r,
                                             input logic [GW-1:0]       last);
      logic [GW-1:0] pick;
      logic          found;
      pick  = last;
      found = 1'b0;
      for (int j = 0; j < NUM_PROC; j++) begin
         if (!found && r[j] && (j > int'(last))) begin
            pick  = GW'(j);
            found = 1'b1;
         end
      end
      for (int j = 0; j < NUM_PROC; j++) begin
         if (!found && r[j] && (j <= int'(last))) begin
            pick  = GW'(j);
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   always_comb begin
      for (int i = 0; i < NUM_PROC; i++) begin
         addr_a[i]  = address[i*ADDR_W +: ADDR_W];
         wdata_a[i] = wdata[i*DATA_W +: DATA_W];
      end
   end

   always_comb begin
      owner_oh             = '0;
      owner_oh[grant_id_q] = 1'b1;
   end

   assign win_idx = rr_pick(req, last_grant_q);

   always_comb begin
      state_d       = state_q;
      ack_d         = ack_q;
      busy_d        = busy_q;
      valid_mem_d   = '0;
      rdata_d       = rdata_q;
      grant_id_d    = grant_id_q;
      timeout_err_d = 1'b0;
      mem_valid_d   = 1'b0;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;
      mem_rw_d      = mem_rw_q;
      cnt_d         = cnt_q;
      last_grant_d  = last_grant_q;

      case (state_q)
         ST_IDLE: begin
            ack_d  = '0;
            busy_d = 1'b0;
            if (|req) begin
               state_d         = ST_GRANT;
               ack_d[win_idx]  = 1'b1;
               busy_d          = 1'b1;
               grant_id_d      = win_idx;
               cnt_d           = '0;
            end
         end

         ST_GRANT: begin
            if (valid[grant_id_q]) begin
               state_d     = ST_WAIT_MEM;
               mem_valid_d = 1'b1;
               mem_addr_d  = addr_a[grant_id_q];
               mem_wdata_d = wdata_a[grant_id_q];
               mem_rw_d    = rw[grant_id_q];
            end else if (!req[grant_id_q]) begin
               state_d      = ST_IDLE;
               ack_d        = '0;
               busy_d       = 1'b0;
               last_grant_d = grant_id_q;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               state_d       = ST_IDLE;
               ack_d         = '0;
               busy_d        = 1'b0;
               timeout_err_d = 1'b1;
               last_grant_d  = grant_id_q;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         // No timeout here: the memory controller always completes.
         ST_WAIT_MEM: begin
            if (mem_ready) begin
               state_d = ST_RELEASE;
               ack_d   = '0;
               if (mem_rw_q) begin
                  rdata_d     = mem_rdata;
                  valid_mem_d = owner_oh;
               end
            end
         end

         ST_RELEASE: begin
            state_d      = ST_IDLE;
            busy_d       = 1'b0;
            last_grant_d = grant_id_q;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         ack_q         <= '0;
         busy_q        <= 1'b0;
         valid_mem_q   <= '0;
         rdata_q       <= '0;
         grant_id_q    <= '0;
         timeout_err_q <= 1'b0;
         mem_valid_q   <= 1'b0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         mem_rw_q      <= 1'b0;
         cnt_q         <= '0;
         last_grant_q  <= GW'(NUM_PROC - 1);
      end else begin
         state_q       <= state_d;
         ack_q         <= ack_d;
         busy_q        <= busy_d;
         valid_mem_q   <= valid_mem_d;
         rdata_q       <= rdata_d;
         grant_id_q    <= grant_id_d;
         timeout_err_q <= timeout_err_d;
         mem_valid_q   <= mem_valid_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
         mem_rw_q      <= mem_rw_d;
         cnt_q         <= cnt_d;
         last_grant_q  <= last_grant_d;
      end
   end

   assign ack         = ack_q;
   assign busy        = busy_q;
   assign valid_mem   = valid_mem_q;
   assign rdata       = rdata_q;
   assign grant_id    = grant_id_q;
   assign timeout_err = timeout_err_q;
   assign mem_valid   = mem_valid_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign mem_rw      = mem_rw_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
//   Directed bench for mem_bus_arbiter (4 processors, 8-bit address/data,
//   timeout 16). Drivers push the bus events they expect into exp_q; a monitor
//   turns every grant, memory strobe, load return and timeout pulse it sees
//   into the same event encoding and compares it against the queue head.
//   The memory stand-in answers a load of address A with A ^ 8'h99.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

   localparam int NP = 4;
   localparam int AW = 8;
   localparam int DW = 8;
   localparam int TO = 16;
   localparam int W  = 24;

   localparam logic [2:0] EV_GRANT  = 3'd1;
   localparam logic [2:0] EV_MEMREQ = 3'd2;
   localparam logic [2:0] EV_RDATA  = 3'd3;
   localparam logic [2:0] EV_TMO    = 3'd4;

   // ---------------- clock / reset ----------------
   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   logic [NP-1:0]    req, valid, rw;
   logic [NP*AW-1:0] address;
   logic [NP*DW-1:0] wdata;
   logic [NP-1:0]    ack, valid_mem;
   logic             busy, timeout_err, mem_valid, mem_rw, mem_ready;
   logic [DW-1:0]    rdata, mem_wdata, mem_rdata;
   logic [AW-1:0]    mem_addr;
   logic [1:0]       grant_id, dbg_state;

   int checks   = 0;
   int failures = 0;
   logic [W-1:0] exp_q[$];
   logic mem_hold = 1'b0;
   int   mem_lat  = 0;

   mem_bus_arbiter #(.NUM_PROC(NP), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req        (req),
      .valid      (valid),
      .rw         (rw),
      .address    (address),
      .wdata      (wdata),
      .ack        (ack),
      .busy       (busy),
      .valid_mem  (valid_mem),
      .rdata      (rdata),
      .grant_id   (grant_id),
      .timeout_err(timeout_err),
      .mem_valid  (mem_valid),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rw     (mem_rw),
      .mem_ready  (mem_ready),
      .mem_rdata  (mem_rdata),
      .dbg_state_o(dbg_state)
   );

   // ---------------- helpers ----------------
   function automatic logic [W-1:0] ev(input logic [2:0] t, input logic [3:0] tag,
                                       input logic [7:0] a, input logic [7:0] d,
                                       input logic r);
      return {t, tag, a, d, r};
   endfunction

   function automatic logic [63:0] outs_vec();
      return {24'd0, ack, busy, valid_mem, rdata, grant_id, timeout_err,
              mem_valid, mem_addr, mem_wdata, mem_rw, dbg_state};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic sb_check(input logic [W-1:0] got);
      logic [W-1:0] exp;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL sb_unexpected: got %h expected none", got);
      end else begin
         exp = exp_q.pop_front();
         if (got !== exp) begin
            failures++;
            $display("FAIL sb_event: got %h expected %h", got, exp);
         end
      end
   endtask

   task automatic wait_ack(input int i, input logic lvl, input int max_cyc,
                           input string name, output int n);
      n = 0;
      while (ack[i] !== lvl && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      chk(name, 64'(ack[i]), 64'(lvl));
   endtask

   // One complete access by processor i from an idle bus.
   task automatic do_access(input int i, input logic [7:0] a, input logic [7:0] d,
                            input logic r, input logic [7:0] exp_rd, input int exp_lat);
      logic [3:0] oh;
      int n;
      oh = 4'b0001 << i;
      exp_q.push_back(ev(EV_GRANT, oh, 8'(i), 8'h00, 1'b0));
      exp_q.push_back(ev(EV_MEMREQ, oh, a, d, r));
      if (r) exp_q.push_back(ev(EV_RDATA, oh, 8'h00, exp_rd, 1'b0));
      address[i*AW +: AW] = a;
      wdata[i*DW +: DW]   = d;
      rw[i]    = r;
      valid[i] = 1'b1;
      req[i]   = 1'b1;
      wait_ack(i, 1'b1, 20, "grant_wait", n);
      chk("grant_latency", 64'(n), 64'(exp_lat));
      wait_ack(i, 1'b0, 40, "release_wait", n);
      chk("release_busy", 64'(busy), 64'd1);
      req[i]   = 1'b0;
      valid[i] = 1'b0;
      @(negedge clk);
      chk("idle_busy", 64'(busy), 64'd0);
   endtask

   // ---------------- memory stand-in ----------------
   initial begin
      mem_ready = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (reset_n && mem_valid && !mem_hold) begin
            repeat (mem_lat) @(negedge clk);
            mem_ready = 1'b1;
            mem_rdata = mem_addr ^ 8'h99;
            @(negedge clk);
            mem_ready = 1'b0;
            mem_rdata = '0;
         end
      end
   end

   // ---------------- monitor ----------------
   initial begin
      logic [NP-1:0] prev_ack;
      prev_ack = '0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            prev_ack = '0;
         end else begin
            chk("ack_onehot0", 64'($onehot0(ack)), 64'd1);
            if (ack != '0 && prev_ack == '0)
               sb_check(ev(EV_GRANT, ack, {6'd0, grant_id}, 8'h00, 1'b0));
            if (mem_valid)
               sb_check(ev(EV_MEMREQ, ack, mem_addr, mem_wdata, mem_rw));
            if (valid_mem != '0)
               sb_check(ev(EV_RDATA, valid_mem, 8'h00, rdata, 1'b0));
            if (timeout_err)
               sb_check(ev(EV_TMO, ack, {6'd0, grant_id}, 8'h00, 1'b0));
            prev_ack = ack;
         end
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus ----------------
   initial begin
      int n, hi;
      int order [5];
      logic [7:0] addr_t [4];
      logic [7:0] rd_t   [4];
      order  = '{0, 1, 2, 3, 0};
      addr_t = '{8'h20, 8'h41, 8'h62, 8'h83};
      rd_t   = '{8'hB9, 8'hD8, 8'hFB, 8'h1A};

      req = '0; valid = '0; rw = '0; address = '0; wdata = '0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", outs_vec(), 64'd0);
      reset_n = 1'b1;
      @(negedge clk);
      chk("idle_after_reset", outs_vec(), 64'd0);

      // single load by proc2
      mem_lat = 0;
      do_access(2, 8'h3C, 8'h00, 1'b1, 8'hA5, 1);
      repeat (2) @(negedge clk);

      // store by proc1, slow memory
      mem_lat = 2;
      do_access(1, 8'h10, 8'h5A, 1'b0, 8'h00, 1);
      repeat (2) @(negedge clk);

      // abandon: proc0 granted, drops req without valid
      exp_q.push_back(ev(EV_GRANT, 4'b0001, 8'd0, 8'h00, 1'b0));
      valid[0] = 1'b0;
      req[0]   = 1'b1;
      wait_ack(0, 1'b1, 20, "t5_grant", n);
      repeat (3) @(negedge clk);
      req[0] = 1'b0;
      @(negedge clk);
      chk("t5_ack_dropped", 64'(ack), 64'd0);
      chk("t5_busy_dropped", 64'(busy), 64'd0);
      repeat (3) @(negedge clk);

      // timeout: proc3 never raises valid, proc0 queues behind it
      mem_lat = 0;
      exp_q.push_back(ev(EV_GRANT, 4'b1000, 8'd3, 8'h00, 1'b0));
      exp_q.push_back(ev(EV_TMO, 4'b0000, 8'd3, 8'h00, 1'b0));
      exp_q.push_back(ev(EV_GRANT, 4'b0001, 8'd0, 8'h00, 1'b0));
      exp_q.push_back(ev(EV_MEMREQ, 4'b0001, 8'h05, 8'h00, 1'b1));
      exp_q.push_back(ev(EV_RDATA, 4'b0001, 8'h00, 8'h9C, 1'b0));
      rw[3] = 1'b0; valid[3] = 1'b0; req[3] = 1'b1;
      wait_ack(3, 1'b1, 20, "t4_grant", n);
      address[0 +: AW] = 8'h05; wdata[0 +: DW] = 8'h00;
      rw[0] = 1'b1; valid[0] = 1'b1; req[0] = 1'b1;
      hi = 1;
      while (hi < 40) begin
         @(negedge clk);
         if (ack[3] !== 1'b1) break;
         hi++;
      end
      chk("t4_grant_cycles", 64'(hi), 64'd16);
      chk("t4_timeout_pulse", 64'(timeout_err), 64'd1);
      req[3] = 1'b0;
      wait_ack(0, 1'b1, 20, "t4_next_grant", n);
      wait_ack(0, 1'b0, 40, "t4_next_release", n);
      req[0] = 1'b0; valid[0] = 1'b0;
      repeat (3) @(negedge clk);

      // store by proc3 so the fairness run starts after proc3
      mem_lat = 1;
      do_access(3, 8'h30, 8'hC3, 1'b0, 8'h00, 1);
      repeat (2) @(negedge clk);

      // fairness: all four hold req and valid
      for (int k = 0; k < 5; k++) begin
         exp_q.push_back(ev(EV_GRANT, 4'b0001 << order[k], 8'(order[k]), 8'h00, 1'b0));
         exp_q.push_back(ev(EV_MEMREQ, 4'b0001 << order[k], addr_t[order[k]], 8'h00, 1'b1));
         exp_q.push_back(ev(EV_RDATA, 4'b0001 << order[k], 8'h00, rd_t[order[k]], 1'b0));
      end
      for (int p = 0; p < NP; p++) address[p*AW +: AW] = addr_t[p];
      wdata = '0; rw = '1; valid = '1; req = '1;
      for (int k = 0; k < 5; k++) begin
         wait_ack(order[k], 1'b1, 20, "t3_grant", n);
         wait_ack(order[k], 1'b0, 40, "t3_release", n);
      end
      req = '0; valid = '0;
      repeat (3) @(negedge clk);

      // reset while waiting on memory
      mem_hold = 1'b1;
      exp_q.push_back(ev(EV_GRANT, 4'b0100, 8'd2, 8'h00, 1'b0));
      exp_q.push_back(ev(EV_MEMREQ, 4'b0100, 8'h77, 8'h00, 1'b1));
      address[2*AW +: AW] = 8'h77;
      rw[2] = 1'b1; valid[2] = 1'b1; req[2] = 1'b1;
      wait_ack(2, 1'b1, 20, "t6_grant", n);
      n = 0;
      while (mem_valid !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("t6_mem_valid_seen", 64'(mem_valid), 64'd1);
      repeat (2) @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("t6_reset_outputs", outs_vec(), 64'd0);
      req = '0; valid = '0;
      repeat (2) @(negedge clk);
      reset_n  = 1'b1;
      mem_hold = 1'b0;
      exp_q.push_back(ev(EV_GRANT, 4'b0001, 8'd0, 8'h00, 1'b0));
      exp_q.push_back(ev(EV_MEMREQ, 4'b0001, 8'h20, 8'h00, 1'b1));
      exp_q.push_back(ev(EV_RDATA, 4'b0001, 8'h00, 8'hB9, 1'b0));
      for (int p = 0; p < NP; p++) address[p*AW +: AW] = addr_t[p];
      wdata = '0; rw = '1; valid = '1; req = '1;
      wait_ack(0, 1'b1, 20, "t6_first_grant", n);
      chk("t6_grant_latency", 64'(n), 64'd1);
      wait_ack(0, 1'b0, 40, "t6_release", n);
      req = '0; valid = '0;

      repeat (5) @(negedge clk);
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
